axi4lite_regfile: RTL and testbench



---
 rtl/axi4lite_pkg.sv | 24 ++
 rtl/axi4lite_hold_reg.sv | 37 +++
 rtl/axi4lite_regfile.sv | 217 +++++++++++++++++++++
 tb/tb_axi4lite_regfile.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4lite_pkg.sv
// Shared types for the AXI4-Lite register file: response codes, FSM states
// and the strobe-width helper.
package axi4lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic {
    WR_COLLECT = 1'b0,
    WR_RESP    = 1'b1
  } wr_state_t;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_VALID = 1'b1
  } rd_state_t;

  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/axi4lite_hold_reg.sv
// One-entry valid/ready holding register: accepts a payload when empty and
// keeps it until the consumer clears it.
module axi4lite_hold_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  input  logic         clear_i,
  output logic         held_o,
  output logic [W-1:0] data_o
);

  logic         held_q;
  logic [W-1:0] data_q;

  assign in_ready_o = en_i && !held_q;
  assign held_o     = held_q;
  assign data_o     = data_q;

  // Load and clear never coincide: loading needs an empty slot, clearing a full one.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      held_q <= 1'b0;
      data_q <= '0;
    end else if (in_valid_i && in_ready_o) begin
      held_q <= 1'b1;
      data_q <= in_data_i;
    end else if (clear_i) begin
      held_q <= 1'b0;
    end
  end

endmodule

// File: rtl/axi4lite_regfile.sv
// Parametrised AXI4-Lite slave register file with per-register write pulses.
// Define AXI4LITE_REGFILE_WSTRB_EN to honour W_STRB byte lanes on writes.
module axi4lite_regfile
  import axi4lite_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input  logic                         A_CLK,
  input  logic                         A_RST,
  input  logic [ADDR_W-1:0]            AW_ADDR,
  input  logic                         AW_VALID,
  output logic                         AW_READY,
  input  logic [DATA_W-1:0]            W_DATA,
  input  logic [strb_w(DATA_W)-1:0]    W_STRB,
  input  logic                         W_VALID,
  output logic                         W_READY,
  output logic [1:0]                   B_RESP,
  output logic                         B_VALID,
  input  logic                         B_READY,
  input  logic [ADDR_W-1:0]            AR_ADDR,
  input  logic                         AR_VALID,
  output logic                         AR_READY,
  output logic [DATA_W-1:0]            R_DATA,
  output logic [1:0]                   R_RESP,
  output logic                         R_VALID,
  input  logic                         R_READY,
  output logic [NUM_REGS*DATA_W-1:0]   REG_Q,
  output logic [NUM_REGS-1:0]          WR_PULSE
);

  localparam int STRB_W = strb_w(DATA_W);
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_W - OFF_W;
  localparam logic [IDX_W:0] NUM_REGS_L = (IDX_W + 1)'(NUM_REGS);

`ifdef AXI4LITE_REGFILE_WSTRB_EN
  localparam int WP_W = DATA_W + STRB_W;
`else
  localparam int WP_W = DATA_W;
`endif

  logic                rst_done_q;
  logic                aw_held, w_held, commit;
  logic [IDX_W-1:0]    aw_idx, ar_idx;
  logic [WP_W-1:0]     w_payload, w_held_data;
  logic [DATA_W-1:0]   w_data_h;
  logic                aw_in_range, ar_in_range;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;

  wr_state_t           wr_state_q, wr_state_d;
  resp_t               b_resp_q, b_resp_d;
  rd_state_t           rd_state_q, rd_state_d;
  resp_t               r_resp_q, r_resp_d;
  logic [DATA_W-1:0]   r_data_q, r_data_d, rd_sel;

  logic                unused_addr;
  assign unused_addr = ^{AW_ADDR[OFF_W-1:0], AR_ADDR[OFF_W-1:0]};

`ifdef AXI4LITE_REGFILE_WSTRB_EN
  logic [STRB_W-1:0] w_strb_h;
  assign w_payload = {W_STRB, W_DATA};
  assign w_strb_h  = w_held_data[WP_W-1:DATA_W];
`else
  logic unused_strb;
  assign unused_strb = ^W_STRB;
  assign w_payload   = W_DATA;
`endif
  assign w_data_h = w_held_data[DATA_W-1:0];

  // READYs stay low until the first edge after reset releases.
  always_ff @(posedge A_CLK or posedge A_RST) begin
    if (A_RST) rst_done_q <= 1'b0;
    else       rst_done_q <= 1'b1;
  end

  axi4lite_hold_reg #(.W(IDX_W)) u_aw_hold (
    .clk_i      (A_CLK),
    .rst_i      (A_RST),
    .en_i       (rst_done_q),
    .in_valid_i (AW_VALID),
    .in_ready_o (AW_READY),
    .in_data_i  (AW_ADDR[ADDR_W-1:OFF_W]),
    .clear_i    (commit),
    .held_o     (aw_held),
    .data_o     (aw_idx)
  );

  axi4lite_hold_reg #(.W(WP_W)) u_w_hold (
    .clk_i      (A_CLK),
    .rst_i      (A_RST),
    .en_i       (rst_done_q),
    .in_valid_i (W_VALID),
    .in_ready_o (W_READY),
    .in_data_i  (w_payload),
    .clear_i    (commit),
    .held_o     (w_held),
    .data_o     (w_held_data)
  );

  assign commit      = (wr_state_q == WR_COLLECT) && aw_held && w_held;
  assign aw_in_range = {1'b0, aw_idx} < NUM_REGS_L;
  assign ar_idx      = AR_ADDR[ADDR_W-1:OFF_W];
  assign ar_in_range = {1'b0, ar_idx} < NUM_REGS_L;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_pulse_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (commit && aw_in_range && (aw_idx == IDX_W'(i))) begin
        wr_pulse_d[i] = 1'b1;
`ifdef AXI4LITE_REGFILE_WSTRB_EN
        for (int k = 0; k < STRB_W; k++) begin
          if (w_strb_h[k]) regs_d[i][k*8 +: 8] = w_data_h[k*8 +: 8];
        end
`else
        regs_d[i] = w_data_h;
`endif
      end
    end
  end

  // NOTE: the register array is reset like any flop; user logic sees zeros after reset.
  always_ff @(posedge A_CLK or posedge A_RST) begin
    if (A_RST) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      wr_pulse_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    b_resp_d   = b_resp_q;
    case (wr_state_q)
      WR_COLLECT: begin
        if (commit) begin
          wr_state_d = WR_RESP;
          b_resp_d   = aw_in_range ? OKAY : SLVERR;
        end
      end
      WR_RESP: begin
        if (B_READY) wr_state_d = WR_COLLECT;
      end
      default: wr_state_d = WR_COLLECT;
    endcase
  end

  always_ff @(posedge A_CLK or posedge A_RST) begin
    if (A_RST) begin
      wr_state_q <= WR_COLLECT;
      b_resp_q   <= OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      b_resp_q   <= b_resp_d;
    end
  end

  // Sampling regs_q here gives the pre-write value when a commit lands on the same edge.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDX_W'(i)) rd_sel = regs_q[i];
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    r_data_d   = r_data_q;
    r_resp_d   = r_resp_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (AR_VALID && AR_READY) begin
          rd_state_d = RD_VALID;
          r_data_d   = ar_in_range ? rd_sel : '0;
          r_resp_d   = ar_in_range ? OKAY : SLVERR;
        end
      end
      RD_VALID: begin
        if (R_READY) rd_state_d = RD_IDLE;
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge A_CLK or posedge A_RST) begin
    if (A_RST) begin
      rd_state_q <= RD_IDLE;
      r_data_q   <= '0;
      r_resp_q   <= OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
    end
  end

  assign AR_READY = rst_done_q && (rd_state_q == RD_IDLE);
  assign R_VALID  = (rd_state_q == RD_VALID);
  assign R_DATA   = r_data_q;
  assign R_RESP   = r_resp_q;
  assign B_VALID  = (wr_state_q == WR_RESP);
  assign B_RESP   = b_resp_q;
  assign WR_PULSE = wr_pulse_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_q
    assign REG_Q[i*DATA_W +: DATA_W] = regs_q[i];
  end

endmodule

// File: tb/tb_axi4lite_regfile.sv
// Directed testbench for axi4lite_regfile (default parameters, 16 x 32-bit).
module tb_axi4lite_regfile;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;
  localparam int STRB_W   = 4;

  logic                       A_CLK = 1'b0;
  logic                       A_RST;
  logic [ADDR_W-1:0]          AW_ADDR;
  logic                       AW_VALID, AW_READY;
  logic [DATA_W-1:0]          W_DATA;
  logic [STRB_W-1:0]          W_STRB;
  logic                       W_VALID, W_READY;
  logic [1:0]                 B_RESP;
  logic                       B_VALID, B_READY;
  logic [ADDR_W-1:0]          AR_ADDR;
  logic                       AR_VALID, AR_READY;
  logic [DATA_W-1:0]          R_DATA;
  logic [1:0]                 R_RESP;
  logic                       R_VALID, R_READY;
  logic [NUM_REGS*DATA_W-1:0] REG_Q;
  logic [NUM_REGS-1:0]        WR_PULSE;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DATA_W-1:0] exp_regs [NUM_REGS];

  axi4lite_regfile #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
    .A_CLK(A_CLK), .A_RST(A_RST),
    .AW_ADDR(AW_ADDR), .AW_VALID(AW_VALID), .AW_READY(AW_READY),
    .W_DATA(W_DATA), .W_STRB(W_STRB), .W_VALID(W_VALID), .W_READY(W_READY),
    .B_RESP(B_RESP), .B_VALID(B_VALID), .B_READY(B_READY),
    .AR_ADDR(AR_ADDR), .AR_VALID(AR_VALID), .AR_READY(AR_READY),
    .R_DATA(R_DATA), .R_RESP(R_RESP), .R_VALID(R_VALID), .R_READY(R_READY),
    .REG_Q(REG_Q), .WR_PULSE(WR_PULSE)
  );

  initial forever #5 A_CLK = ~A_CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [NUM_REGS*DATA_W-1:0] exp_flat();
    logic [NUM_REGS*DATA_W-1:0] f;
    for (int i = 0; i < NUM_REGS; i++) f[i*DATA_W +: DATA_W] = exp_regs[i];
    return f;
  endfunction

  task automatic tick();
    @(posedge A_CLK);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                          input logic [STRB_W-1:0] strb, output logic [1:0] resp,
                          output logic [NUM_REGS-1:0] pulse_or, output int pulse_cycles,
                          output bit timeout);
    bit aw_pend, w_pend, aw_fire, w_fire, got_b;
    int n;
    AW_ADDR = addr; W_DATA = data; W_STRB = strb;
    AW_VALID = 1'b1; W_VALID = 1'b1;
    aw_pend = 1'b1; w_pend = 1'b1; n = 0;
    resp = 2'b11; pulse_or = '0; pulse_cycles = 0; got_b = 1'b0;
    while ((aw_pend || w_pend) && n < 20) begin
      aw_fire = AW_VALID && AW_READY;
      w_fire  = W_VALID && W_READY;
      tick(); n++;
      if (aw_fire) begin AW_VALID = 1'b0; aw_pend = 1'b0; end
      if (w_fire)  begin W_VALID = 1'b0;  w_pend = 1'b0;  end
    end
    AW_VALID = 1'b0; W_VALID = 1'b0;
    B_READY = 1'b1; n = 0;
    while (!got_b && n < 20) begin
      if (WR_PULSE != '0) begin pulse_or |= WR_PULSE; pulse_cycles++; end
      if (B_VALID) begin resp = B_RESP; got_b = 1'b1; end
      tick(); n++;
    end
    B_READY = 1'b0;
    if (WR_PULSE != '0) begin pulse_or |= WR_PULSE; pulse_cycles++; end
    timeout = aw_pend || w_pend || !got_b;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] addr, output logic [DATA_W-1:0] data,
                         output logic [1:0] resp, output bit timeout);
    bit fired, f, got;
    int n;
    AR_ADDR = addr; AR_VALID = 1'b1;
    fired = 1'b0; got = 1'b0; n = 0;
    data = 'x; resp = 2'b11;
    while (!fired && n < 20) begin
      f = AR_READY;
      tick(); n++;
      if (f) fired = 1'b1;
    end
    AR_VALID = 1'b0; R_READY = 1'b1; n = 0;
    while (!got && n < 20) begin
      if (R_VALID) begin data = R_DATA; resp = R_RESP; got = 1'b1; end
      tick(); n++;
    end
    R_READY = 1'b0;
    timeout = !fired || !got;
  endtask

  task automatic test_reset();
    A_RST = 1'b1;
    AW_ADDR = '0; AW_VALID = 1'b0; W_DATA = '0; W_STRB = '0; W_VALID = 1'b0;
    B_READY = 1'b0; AR_ADDR = '0; AR_VALID = 1'b0; R_READY = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = '0;
    repeat (3) tick();
    tests_run++; if ({AW_READY, W_READY, AR_READY, B_VALID, R_VALID} !== 5'b0) begin tests_failed++; $display("FAIL reset_handshake: got %b required 00000", {AW_READY, W_READY, AR_READY, B_VALID, R_VALID}); end
    tests_run++; if ({B_RESP, R_RESP, R_DATA} !== '0) begin tests_failed++; $display("FAIL reset_resp_data: got %h required 0", {B_RESP, R_RESP, R_DATA}); end
    tests_run++; if (REG_Q !== exp_flat()) begin tests_failed++; $display("FAIL reset_reg_q: got %h required %h", REG_Q, exp_flat()); end
    tests_run++; if (WR_PULSE !== '0) begin tests_failed++; $display("FAIL reset_wr_pulse: got %h required 0", WR_PULSE); end
    A_RST = 1'b0;
    #1;
    tests_run++; if ({AW_READY, W_READY, AR_READY} !== 3'b000) begin tests_failed++; $display("FAIL ready_before_edge: got %b required 000", {AW_READY, W_READY, AR_READY}); end
    tick();
    tests_run++; if ({AW_READY, W_READY, AR_READY} !== 3'b111) begin tests_failed++; $display("FAIL ready_after_edge: got %b required 111", {AW_READY, W_READY, AR_READY}); end
  endtask

  task automatic test_write_read();
    logic [1:0] resp; logic [NUM_REGS-1:0] pulses; int pcyc; bit to;
    logic [DATA_W-1:0] rdata;
    do_write(8'h04, 32'hDEADBEEF, 4'hF, resp, pulses, pcyc, to);
    exp_regs[1] = 32'hDEADBEEF;
    tests_run++; if (to !== 1'b0) begin tests_failed++; $display("FAIL wr_timeout: got %b required 0", to); end
    tests_run++; if (resp !== 2'b00) begin tests_failed++; $display("FAIL wr_bresp: got %b required 00", resp); end
    tests_run++; if (pulses !== 16'h0002 || pcyc != 1) begin tests_failed++; $display("FAIL wr_pulse: got %h x%0d required 0002 x1", pulses, pcyc); end
    tests_run++; if (REG_Q !== exp_flat()) begin tests_failed++; $display("FAIL wr_reg_q: got %h required %h", REG_Q, exp_flat()); end
    do_read(8'h04, rdata, resp, to);
    tests_run++; if (to !== 1'b0 || rdata !== 32'hDEADBEEF || resp !== 2'b00) begin tests_failed++; $display("FAIL rd_04: got %h/%b to=%b required deadbeef/00", rdata, resp, to); end
    do_read(8'h07, rdata, resp, to);
    tests_run++; if (to !== 1'b0 || rdata !== 32'hDEADBEEF || resp !== 2'b00) begin tests_failed++; $display("FAIL rd_subword: got %h/%b to=%b required deadbeef/00", rdata, resp, to); end
  endtask

  task automatic test_w_before_aw();
    tests_run++; if (W_READY !== 1'b1) begin tests_failed++; $display("FAIL wfirst_ready_idle: got %b required 1", W_READY); end
    W_DATA = 32'h12345678; W_STRB = 4'hF; W_VALID = 1'b1;
    tick();
    W_VALID = 1'b0;
    tests_run++; if (W_READY !== 1'b0) begin tests_failed++; $display("FAIL wfirst_ready_drop: got %b required 0", W_READY); end
    repeat (2) tick();
    tests_run++; if ({W_READY, B_VALID} !== 2'b00) begin tests_failed++; $display("FAIL wfirst_waiting: got %b required 00", {W_READY, B_VALID}); end
    AW_ADDR = 8'h08; AW_VALID = 1'b1;
    tests_run++; if (AW_READY !== 1'b1) begin tests_failed++; $display("FAIL wfirst_aw_ready: got %b required 1", AW_READY); end
    tick();
    AW_VALID = 1'b0;
    tests_run++; if (B_VALID !== 1'b0 || REG_Q[2*DATA_W +: DATA_W] !== 32'h0) begin tests_failed++; $display("FAIL wfirst_early_commit: got bvalid=%b reg2=%h required 0/0", B_VALID, REG_Q[2*DATA_W +: DATA_W]); end
    tick();
    exp_regs[2] = 32'h12345678;
    tests_run++; if (B_VALID !== 1'b1 || B_RESP !== 2'b00) begin tests_failed++; $display("FAIL wfirst_b: got %b/%b required 1/00", B_VALID, B_RESP); end
    tests_run++; if (WR_PULSE !== 16'h0004) begin tests_failed++; $display("FAIL wfirst_pulse: got %h required 0004", WR_PULSE); end
    tests_run++; if (REG_Q !== exp_flat()) begin tests_failed++; $display("FAIL wfirst_reg_q: got %h required %h", REG_Q, exp_flat()); end
    tests_run++; if ({AW_READY, W_READY} !== 2'b11) begin tests_failed++; $display("FAIL wfirst_ready_back: got %b required 11", {AW_READY, W_READY}); end
    B_READY = 1'b1;
    tick();
    B_READY = 1'b0;
    tests_run++; if ({B_VALID, WR_PULSE} !== '0) begin tests_failed++; $display("FAIL wfirst_done: got bvalid=%b pulse=%h required 0/0", B_VALID, WR_PULSE); end
  endtask

  task automatic test_strobe();
    logic [1:0] resp; logic [NUM_REGS-1:0] pulses; int pcyc; bit to;
    do_write(8'h00, 32'hFFFFFFFF, 4'b0101, resp, pulses, pcyc, to);
`ifdef AXI4LITE_REGFILE_WSTRB_EN
    exp_regs[0] = 32'h00FF00FF;
`else
    exp_regs[0] = 32'hFFFFFFFF;
`endif
    tests_run++; if (to !== 1'b0 || resp !== 2'b00 || pulses !== 16'h0001) begin tests_failed++; $display("FAIL strb_resp: got to=%b resp=%b pulse=%h required 0/00/0001", to, resp, pulses); end
    tests_run++; if (REG_Q[DATA_W-1:0] !== exp_regs[0]) begin tests_failed++; $display("FAIL strb_reg0: got %h required %h", REG_Q[DATA_W-1:0], exp_regs[0]); end
  endtask

  task automatic test_out_of_range();
    logic [1:0] resp; logic [NUM_REGS-1:0] pulses; int pcyc; bit to;
    logic [DATA_W-1:0] rdata;
    do_write(8'h40, 32'hA5A5A5A5, 4'hF, resp, pulses, pcyc, to);
    tests_run++; if (to !== 1'b0 || resp !== 2'b10) begin tests_failed++; $display("FAIL oor_bresp: got %b to=%b required 10", resp, to); end
    tests_run++; if (pulses !== '0 || pcyc != 0) begin tests_failed++; $display("FAIL oor_pulse: got %h x%0d required 0000 x0", pulses, pcyc); end
    tests_run++; if (REG_Q !== exp_flat()) begin tests_failed++; $display("FAIL oor_reg_q: got %h required %h", REG_Q, exp_flat()); end
    do_read(8'h40, rdata, resp, to);
    tests_run++; if (to !== 1'b0 || rdata !== 32'h0 || resp !== 2'b10) begin tests_failed++; $display("FAIL oor_rd_40: got %h/%b to=%b required 0/10", rdata, resp, to); end
    do_read(8'hFC, rdata, resp, to);
    tests_run++; if (to !== 1'b0 || rdata !== 32'h0 || resp !== 2'b10) begin tests_failed++; $display("FAIL oor_rd_fc: got %h/%b to=%b required 0/10", rdata, resp, to); end
    do_write(8'h3C, 32'hCAFEF00D, 4'hF, resp, pulses, pcyc, to);
    exp_regs[15] = 32'hCAFEF00D;
    tests_run++; if (to !== 1'b0 || resp !== 2'b00 || pulses !== 16'h8000) begin tests_failed++; $display("FAIL last_reg_wr: got resp=%b pulse=%h to=%b required 00/8000", resp, pulses, to); end
    do_read(8'h3C, rdata, resp, to);
    tests_run++; if (to !== 1'b0 || rdata !== 32'hCAFEF00D || resp !== 2'b00) begin tests_failed++; $display("FAIL last_reg_rd: got %h/%b to=%b required cafef00d/00", rdata, resp, to); end
  endtask

  task automatic test_back_pressure();
    bit aw_fire, w_fire;
    B_READY = 1'b0;
    AW_ADDR = 8'h80; W_DATA = 32'h11111111; W_STRB = 4'hF;
    AW_VALID = 1'b1; W_VALID = 1'b1;
    tick();
    AW_VALID = 1'b0; W_VALID = 1'b0;
    tick();
    tests_run++; if (B_VALID !== 1'b1 || B_RESP !== 2'b10) begin tests_failed++; $display("FAIL bp_first_b: got %b/%b required 1/10", B_VALID, B_RESP); end
    AW_ADDR = 8'h10; W_DATA = 32'h22222222;
    AW_VALID = 1'b1; W_VALID = 1'b1;
    for (int c = 0; c < 5; c++) begin
      aw_fire = AW_VALID && AW_READY;
      w_fire  = W_VALID && W_READY;
      tick();
      if (aw_fire) AW_VALID = 1'b0;
      if (w_fire)  W_VALID = 1'b0;
      tests_run++; if (B_VALID !== 1'b1 || B_RESP !== 2'b10) begin tests_failed++; $display("FAIL bp_hold_c%0d: got %b/%b required 1/10", c, B_VALID, B_RESP); end
    end
    tests_run++; if ({AW_VALID, W_VALID, AW_READY, W_READY} !== 4'b0000) begin tests_failed++; $display("FAIL bp_second_held: got %b required 0000", {AW_VALID, W_VALID, AW_READY, W_READY}); end
    tests_run++; if (REG_Q[4*DATA_W +: DATA_W] !== 32'h0 || WR_PULSE !== '0) begin tests_failed++; $display("FAIL bp_no_early_commit: got reg4=%h pulse=%h required 0/0", REG_Q[4*DATA_W +: DATA_W], WR_PULSE); end
    B_READY = 1'b1;
    tick();
    B_READY = 1'b0;
    tests_run++; if (B_VALID !== 1'b0 || REG_Q[4*DATA_W +: DATA_W] !== 32'h0) begin tests_failed++; $display("FAIL bp_after_b: got bvalid=%b reg4=%h required 0/0", B_VALID, REG_Q[4*DATA_W +: DATA_W]); end
    tick();
    exp_regs[4] = 32'h22222222;
    tests_run++; if (B_VALID !== 1'b1 || B_RESP !== 2'b00 || WR_PULSE !== 16'h0010) begin tests_failed++; $display("FAIL bp_second_commit: got %b/%b pulse=%h required 1/00/0010", B_VALID, B_RESP, WR_PULSE); end
    tests_run++; if (REG_Q !== exp_flat()) begin tests_failed++; $display("FAIL bp_reg_q: got %h required %h", REG_Q, exp_flat()); end
    B_READY = 1'b1;
    tick();
    B_READY = 1'b0;
  endtask

  task automatic test_read_during_commit();
    AW_ADDR = 8'h04; W_DATA = 32'h0BADF00D; W_STRB = 4'hF;
    AW_VALID = 1'b1; W_VALID = 1'b1;
    tick();
    AW_VALID = 1'b0; W_VALID = 1'b0;
    AR_ADDR = 8'h04; AR_VALID = 1'b1;
    tests_run++; if (AR_READY !== 1'b1) begin tests_failed++; $display("FAIL rdc_ar_ready: got %b required 1", AR_READY); end
    tick();
    AR_VALID = 1'b0;
    exp_regs[1] = 32'h0BADF00D;
    tests_run++; if (R_VALID !== 1'b1 || R_DATA !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL rdc_old_value: got %b/%h required 1/deadbeef", R_VALID, R_DATA); end
    tests_run++; if (B_VALID !== 1'b1 || REG_Q !== exp_flat()) begin tests_failed++; $display("FAIL rdc_commit: got bvalid=%b reg_q=%h required 1/%h", B_VALID, REG_Q, exp_flat()); end
    B_READY = 1'b1; R_READY = 1'b1;
    tick();
    B_READY = 1'b0; R_READY = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [DATA_W-1:0] rdata; logic [1:0] resp; bit to;
    AW_ADDR = 8'h00; AW_VALID = 1'b1;
    tick();
    AW_VALID = 1'b0;
    W_DATA = 32'h5A5A5A5A; W_STRB = 4'hF; W_VALID = 1'b1;
    tests_run++; if (AW_READY !== 1'b0) begin tests_failed++; $display("FAIL rstmid_aw_held: got %b required 0", AW_READY); end
    #2;
    A_RST = 1'b1;
    #1;
    for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = '0;
    tests_run++; if ({AW_READY, W_READY, AR_READY, B_VALID, R_VALID} !== 5'b0) begin tests_failed++; $display("FAIL rstmid_handshake: got %b required 00000", {AW_READY, W_READY, AR_READY, B_VALID, R_VALID}); end
    tests_run++; if ({B_RESP, R_RESP, R_DATA, WR_PULSE} !== '0) begin tests_failed++; $display("FAIL rstmid_outputs: got %h required 0", {B_RESP, R_RESP, R_DATA, WR_PULSE}); end
    tests_run++; if (REG_Q !== exp_flat()) begin tests_failed++; $display("FAIL rstmid_reg_q: got %h required 0", REG_Q); end
    W_VALID = 1'b0;
    tick();
    A_RST = 1'b0;
    repeat (3) tick();
    tests_run++; if (B_VALID !== 1'b0 || REG_Q !== exp_flat()) begin tests_failed++; $display("FAIL rstmid_no_stale: got bvalid=%b reg_q=%h required 0/0", B_VALID, REG_Q); end
    do_read(8'h00, rdata, resp, to);
    tests_run++; if (to !== 1'b0 || rdata !== 32'h0 || resp !== 2'b00) begin tests_failed++; $display("FAIL rstmid_read: got %h/%b to=%b required 0/00", rdata, resp, to); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_w_before_aw();
    test_strobe();
    test_out_of_range();
    test_back_pressure();
    test_read_during_commit();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
